sim_host_device: RTL and testbench

// - Memory-mapped simulation host: the program-side end of the core test harness.
// - Responds to core data-memory requests in a 16-byte window:
//   - latches the program's exit/pass code (TOHOST);
//   - buffers console bytes for the testbench;
//   - exposes a free-running cycle counter.
// - Lets the running program end simulation itself instead of a fixed cycle count.
// - Sits beside data memory on the core's memory-stage bus; HALT/PASS/CON_* go to the testbench.

---
 rtl/sim_host_device_pkg.sv | 27 ++
 rtl/sim_host_device_if.sv | 21 ++
 rtl/sim_host_device_sync_fifo.sv | 66 ++++++
 rtl/sim_host_device.sv | 175 +++++++++++++++++
 tb/tb_sim_host_device.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_host_device_pkg.sv
// Shared definitions for the simulation host: register offsets inside the
// 16-byte window, the packed STATUS register layout and the offset decoder.
package sim_host_device_pkg;

    localparam logic [3:0] SIMHOST_OFF_TOHOST  = 4'h0;
    localparam logic [3:0] SIMHOST_OFF_CONSOLE = 4'h4;
    localparam logic [3:0] SIMHOST_OFF_CYCLE   = 4'h8;
    localparam logic [3:0] SIMHOST_OFF_STATUS  = 4'hC;

    // STATUS read value, MSB first
    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  fifo_count;
        logic [3:0]  rsvd_lo;
        logic        timeout;
        logic        overflow;
        logic        pass;
        logic        halt;
    } simhost_status_t;

    // Word select (ADDR[3:2]) to register offset; byte lanes are ignored so
    // misaligned accesses land on the enclosing word.
    function automatic logic [3:0] simhost_offset(input logic [1:0] word_sel);
        return {word_sel, 2'b00};
    endfunction

endpackage

// File: rtl/sim_host_device_if.sv
// Core memory-stage request/response bus as seen by the simulation host.
// master = core side, slave = sim_host_device.
interface sim_host_device_if;
    logic        REQ_VALID;
    logic        REQ_WE;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic [3:0]  REQ_BE;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;

    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_BE,
        input  RSP_VALID, RSP_RDATA
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_BE,
        output RSP_VALID, RSP_RDATA
    );
endinterface

// File: rtl/sim_host_device_sync_fifo.sv
// Single-clock FIFO used as the console byte buffer. A push into a full FIFO
// is accepted when a pop happens in the same cycle; otherwise it is dropped
// (the caller decides what to do about that). DEPTH must be a power of 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Occupancy next state: simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sim_host_device.sv
// Simulation host: a 16-byte memory-mapped window beside data memory that
// lets the program end simulation (TOHOST), print console bytes and read a
// free-running cycle counter.
// Optional feature macro: SIM_WATCHDOG_EN -- when defined, a watchdog halts
// the run with TIMEOUT after TIMEOUT_CYCLES cycles without a TOHOST write.
module sim_host_device
    import sim_host_device_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_FF00,
    parameter int          CON_DEPTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic               CLK,
    input  logic               RST_N,
    sim_host_device_if.slave   bus,
    output logic               CON_VALID,
    output logic [7:0]         CON_DATA,
    input  logic               CON_READY,
    output logic               HALT,
    output logic               PASS,
    output logic [30:0]        EXIT_CODE,
    output logic               TIMEOUT
);

    localparam int CW = $clog2(CON_DEPTH + 1);

    logic            hit;
    logic [3:0]      off;
    logic            tohost_wr;
    logic            con_push;
    logic            con_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      fifo_head;
    logic [CW-1:0]   fifo_count;
    logic            overflow_q;
    logic            halt_q;
    logic            pass_q;
    logic [30:0]     exit_q;
    logic [31:0]     cycle_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic [31:0]     rsp_rdata_d;
    simhost_status_t status;
    logic            unused_ok;

    assign hit       = bus.REQ_VALID && (bus.REQ_ADDR[31:4] == BASE_ADDR[31:4]);
    assign off       = simhost_offset(bus.REQ_ADDR[3:2]);
    assign tohost_wr = hit && bus.REQ_WE && (off == SIMHOST_OFF_TOHOST) &&
                       (bus.REQ_BE == 4'hF) && bus.REQ_WDATA[0];
    assign con_push  = hit && bus.REQ_WE && (off == SIMHOST_OFF_CONSOLE) && bus.REQ_BE[0];
    assign con_pop   = CON_VALID && CON_READY;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (CON_DEPTH)
    ) u_con_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (con_push),
        .wdata_i (bus.REQ_WDATA[7:0]),
        .pop_i   (con_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign CON_VALID = !fifo_empty;
    // Stale storage is masked so the byte lane reads 0 while nothing is queued
    assign CON_DATA  = fifo_empty ? 8'h00 : fifo_head;

`ifdef SIM_WATCHDOG_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic wd_fire;
    logic timeout_q;

    assign wd_fire = !halt_q && (cycle_q == WD_LAST);

    // Watchdog flag: a TOHOST write in the firing cycle pre-empts it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            timeout_q <= 1'b0;
        end else if (wd_fire && !tohost_wr) begin
            timeout_q <= 1'b1;
        end
    end

    assign TIMEOUT   = timeout_q;
    assign unused_ok = ^bus.REQ_ADDR[1:0];
`else
    assign TIMEOUT   = 1'b0;
    assign unused_ok = ^{bus.REQ_ADDR[1:0], TIMEOUT_CYCLES};
`endif

    // STATUS snapshot as seen in the request cycle
    always_comb begin
        status            = '0;
        status.fifo_count = 8'(fifo_count);
        status.timeout    = TIMEOUT;
        status.overflow   = overflow_q;
        status.pass       = pass_q;
        status.halt       = halt_q;
    end

    // Read mux; writes and write-only registers return 0
    always_comb begin
        rsp_rdata_d = '0;
        if (hit && !bus.REQ_WE) begin
            case (off)
                SIMHOST_OFF_CYCLE:  rsp_rdata_d = cycle_q;
                SIMHOST_OFF_STATUS: rsp_rdata_d = status;
                default:            rsp_rdata_d = '0;
            endcase
        end
    end

    // One-cycle acknowledge for every hit, defined offset or not
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= hit;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Free-running cycle counter, wraps at 2^32
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // Sticky console overflow: push into a full FIFO with no pop to make room
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow_q <= 1'b0;
        end else if (con_push && fifo_full && !con_pop) begin
            overflow_q <= 1'b1;
        end
    end

    // Halt/exit latch: the first terminating event wins, later ones are ignored
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            halt_q <= 1'b0;
            pass_q <= 1'b0;
            exit_q <= '0;
        end else if (!halt_q) begin
            if (tohost_wr) begin
                halt_q <= 1'b1;
                pass_q <= (bus.REQ_WDATA[31:1] == 31'd0);
                exit_q <= bus.REQ_WDATA[31:1];
            end
`ifdef SIM_WATCHDOG_EN
            else if (wd_fire) begin
                halt_q <= 1'b1;
                pass_q <= 1'b0;
                exit_q <= 31'h7FFF_FFFF;
            end
`endif
        end
    end

    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_RDATA = rsp_rdata_q;
    assign HALT          = halt_q;
    assign PASS          = pass_q;
    assign EXIT_CODE     = exit_q;

endmodule

// File: tb/tb_sim_host_device.sv
// Bench for sim_host_device: directed scenarios plus random traffic, checked
// by a scoreboard fed from a transaction-level reference model.
module tb_sim_host_device;

`ifdef SIM_WATCHDOG_EN
    localparam int unsigned TO = 50;
    localparam bit          WD = 1'b1;
`else
    localparam int unsigned TO = 100000;
    localparam bit          WD = 1'b0;
`endif
    localparam logic [31:0] BASE  = 32'hFFFF_FF00;
    localparam int          DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CON_READY = 1'b0;
    logic        CON_VALID;
    logic [7:0]  CON_DATA;
    logic        HALT;
    logic        PASS;
    logic [30:0] EXIT_CODE;
    logic        TIMEOUT;

    sim_host_device_if bus();

    sim_host_device #(
        .BASE_ADDR      (BASE),
        .CON_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus),
        .CON_VALID (CON_VALID),
        .CON_DATA  (CON_DATA),
        .CON_READY (CON_READY),
        .HALT      (HALT),
        .PASS      (PASS),
        .EXIT_CODE (EXIT_CODE),
        .TIMEOUT   (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference model state
    bit          m_halt, m_pass, m_timeout, m_over;
    logic [30:0] m_exit;
    int          m_cnt;
    logic [31:0] m_cycle;
    logic [7:0]  exp_con[$];

    typedef struct {
        int          due;
        bit          vld;
        bit          has_data;
        logic [31:0] data;
    } rsp_t;
    rsp_t exp_rsp[$];
    rsp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] off);
        case (off)
            4'h8:    return m_cycle;
            4'hC:    return {16'h0, 8'(m_cnt), 4'h0, m_timeout, m_over, m_pass, m_halt};
            default: return 32'h0;
        endcase
    endfunction

    // Drive one cycle of bus/console inputs, predict the response, advance the model
    task automatic step(input bit v, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input bit rdy);
        bit hit, push, pop, push_ok;
        logic [3:0] off;
        rsp_t e;
        bus.REQ_VALID = v;
        bus.REQ_WE    = we;
        bus.REQ_ADDR  = addr;
        bus.REQ_WDATA = wdata;
        bus.REQ_BE    = be;
        CON_READY     = rdy;
        hit = v && (addr[31:4] == BASE[31:4]);
        off = {addr[3:2], 2'b00};
        e.due      = cyc + 1;
        e.vld      = hit;
        e.has_data = hit && !we;
        e.data     = model_read(off);
        exp_rsp.push_back(e);
        @(posedge CLK);
        pop     = (m_cnt > 0) && rdy;
        push    = hit && we && (off == 4'h4) && be[0];
        push_ok = push && ((m_cnt < DEPTH) || pop);
        if (push && !push_ok) m_over = 1'b1;
        if (push_ok) exp_con.push_back(wdata[7:0]);
        m_cnt = m_cnt + int'(push_ok) - int'(pop);
        if (!m_halt) begin
            if (hit && we && off == 4'h0 && be == 4'hF && wdata[0]) begin
                m_halt = 1'b1;
                m_exit = wdata[31:1];
                m_pass = (wdata[31:1] == 31'd0);
            end else if (WD && m_cycle == TO - 1) begin
                m_halt    = 1'b1;
                m_timeout = 1'b1;
                m_pass    = 1'b0;
                m_exit    = '1;
            end
        end
        m_cycle = m_cycle + 32'd1;
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rdy);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        bus.REQ_VALID = 1'b0;
        bus.REQ_WE    = 1'b0;
        bus.REQ_ADDR  = '0;
        bus.REQ_WDATA = '0;
        bus.REQ_BE    = '0;
        CON_READY     = 1'b0;
        exp_rsp.delete();
        exp_con.delete();
        m_halt = 0; m_pass = 0; m_timeout = 0; m_over = 0;
        m_exit = '0; m_cnt = 0; m_cycle = '0;
        #1;
        chk("reset_bus", {bus.RSP_VALID, bus.RSP_RDATA}, 64'h0);
        chk("reset_outputs", {CON_VALID, CON_DATA, HALT, PASS, EXIT_CODE, TIMEOUT}, 64'h0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    // Monitor: responses and console bytes against the scoreboard queues
    always @(negedge CLK) begin
        if (RST_N) begin
            if (exp_rsp.size() > 0 && exp_rsp[0].due == cyc) begin
                mon_e = exp_rsp.pop_front();
                chk("rsp_valid", bus.RSP_VALID, mon_e.vld);
                if (mon_e.has_data) chk("rsp_rdata", bus.RSP_RDATA, mon_e.data);
            end else begin
                chk("rsp_idle", bus.RSP_VALID, 1'b0);
            end
            chk("halt", HALT, m_halt);
            chk("pass", PASS, m_pass);
            chk("exit_code", EXIT_CODE, m_exit);
            chk("timeout", TIMEOUT, m_timeout);
            chk("con_valid", CON_VALID, m_cnt > 0);
            if (CON_VALID && CON_READY) begin
                if (exp_con.size() == 0) begin
                    n_checks++;
                    $display("FAIL con_data: got %0h expected no byte", CON_DATA);
                end else begin
                    chk("con_data", CON_DATA, exp_con.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got %0d cycles expected completion", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        do_reset();

        // STATUS right after reset, single-cycle acknowledge
        step(1, 0, BASE + 32'hC, 0, 4'h0, 0);
        chk("rst_status_rsp_valid", bus.RSP_VALID, 1'b1);
        chk("rst_status_rdata", bus.RSP_RDATA, 32'h0);
        idle(0);
        chk("rsp_one_cycle", bus.RSP_VALID, 1'b0);

        // Pass exit, then a later TOHOST write is ignored
        step(1, 1, BASE, 32'h1, 4'hF, 0);
        chk("tohost1_halt_pass", {HALT, PASS}, 2'b11);
        chk("tohost1_exit", EXIT_CODE, 31'd0);
        step(1, 1, BASE, 32'h7, 4'hF, 0);
        chk("tohost_second_ignored", {HALT, PASS, EXIT_CODE}, {2'b11, 31'd0});

        // Partial byte enables do not qualify; failing exit code 3
        do_reset();
        step(1, 1, BASE, 32'h1, 4'h1, 0);
        chk("tohost_be_ignored", HALT, 1'b0);
        step(1, 1, BASE, 32'h7, 4'hF, 0);
        chk("tohost7", {HALT, PASS, EXIT_CODE}, {2'b10, 31'd3});

        // Console "Hi\n" with the consumer always ready
        do_reset();
        step(1, 1, BASE + 32'h4, 32'h48, 4'hF, 1);
        chk("con_H", {CON_VALID, CON_DATA}, 9'h148);
        step(1, 1, BASE + 32'h4, 32'h69, 4'hF, 1);
        chk("con_i", {CON_VALID, CON_DATA}, 9'h169);
        step(1, 1, BASE + 32'h4, 32'h0A, 4'hF, 1);
        chk("con_nl", {CON_VALID, CON_DATA}, 9'h10A);
        idle(1);
        chk("con_drained", CON_VALID, 1'b0);

        // Overflow: 17 pushes into 16 entries, then push+pop while full
        do_reset();
        for (int i = 0; i < 17; i++) step(1, 1, BASE + 32'h4, 32'(i), 4'h1, 0);
        step(1, 0, BASE + 32'hC, 0, 4'h0, 0);
        chk("status_full_ovf", bus.RSP_RDATA, 32'h0000_1004);
        step(1, 1, BASE + 32'h4, 32'hAA, 4'h1, 1);
        chk("head_after_pushpop", CON_DATA, 8'h01);
        step(1, 0, BASE + 32'hC, 0, 4'h0, 0);
        chk("status_pushpop_full", bus.RSP_RDATA, 32'h0000_1004);
        for (int i = 0; i < 17; i++) idle(1);
        chk("con_all_drained", exp_con.size(), 0);

        // Window miss: no acknowledge, no console push
        step(1, 0, 32'hFFFF_FF10, 0, 4'h0, 0);
        chk("miss_no_rsp", bus.RSP_VALID, 1'b0);
        step(1, 1, 32'hFFFF_FF14, 32'h55, 4'hF, 0);
        chk("miss_no_push", {bus.RSP_VALID, CON_VALID}, 2'b00);

        // Cycle counter, misaligned read, ignored write to read-only registers
        do_reset();
        step(1, 0, BASE + 32'h8, 0, 4'h0, 0);
        chk("cycle0", bus.RSP_RDATA, 32'd0);
        step(1, 0, BASE + 32'hB, 0, 4'h0, 0);
        chk("cycle_misaligned", bus.RSP_RDATA, 32'd1);
        step(1, 1, BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, 0);
        step(1, 1, BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, 0);
        step(1, 0, BASE + 32'hC, 0, 4'h0, 0);
        chk("status_ro", bus.RSP_RDATA, 32'h0);
        step(1, 0, BASE + 32'h8, 0, 4'h0, 0);
        chk("cycle5", bus.RSP_RDATA, 32'd5);

`ifdef SIM_WATCHDOG_EN
        // Watchdog with no TOHOST write
        do_reset();
        for (int i = 0; i < 49; i++) idle(0);
        chk("wd_not_yet", HALT, 1'b0);
        idle(0);
        chk("wd_fired", {HALT, TIMEOUT, PASS}, 3'b110);
        chk("wd_exit", EXIT_CODE, 31'h7FFF_FFFF);
`endif

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, d;
            logic [3:0]  b;
            bit          v;
            v = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) a = BASE ^ (32'h10 << $urandom_range(0, 27));
            else a = BASE | 32'($urandom_range(0, 15));
            d = $urandom;
            if (a[3:2] == 2'b00 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
            b = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            step(v, 1'($urandom_range(0, 1)), a, d, b, 1'($urandom_range(0, 1)));
        end
        idle(1);
        @(negedge CLK);
        #1;
        chk("rsp_queue_drained", exp_rsp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
